// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control, redirect, instruction-memory and
// IF/ID pipeline-register signals. The fetch stage sits on the slave side;
// the hazard unit, ID stage and instruction memory sit on the master side.
// There is no valid/ready handshake here. if_id_valid is a qualifier: when it
// is 1, if_id_instr/if_id_pc4 hold a real fetched instruction; when it is 0,
// they hold a bubble. Stalls use the pc_write/if_id_write enables instead of
// ready.
interface if_stage_if #(
  parameter int CNT_W = 16
);
  logic             pc_write;
  logic             if_id_write;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump;
  logic [31:0]      jump_target;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic [31:0]      pc;
  logic [31:0]      if_id_instr;
  logic [31:0]      if_id_pc4;
  logic             if_id_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output pc_write, if_id_write, branch_taken, branch_target,
           jump, jump_target, imem_rdata,
    input  imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  pc_write, if_id_write, branch_taken, branch_target,
           jump, jump_target, imem_rdata,
    output imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register with stall/branch/jump selection,
// IF/ID pipeline register with flush, and saturating stall/flush counters.
// Every output comes straight from a register, so imem_rdata never reaches
// an output combinationally.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  if_stage_if.slave bus
);

  localparam logic [31:0]      WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_plus4;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             redirect;

  // Wraps naturally at 2^32: 32'hFFFF_FFFC + 4 gives 0.
  assign pc_plus4 = pc_q + 32'd4;

  // A flush only happens when IF/ID is allowed to update. A held IF/ID keeps
  // its contents even when a redirect is requested.
  assign redirect = bus.if_id_write & (bus.branch_taken | bus.jump);

  // Next-PC select: stall wins, then branch, then jump, then sequential.
  always_comb begin
    pc_d = pc_plus4;
    if (!bus.pc_write) begin
      pc_d = pc_q;
    end else if (bus.branch_taken) begin
      pc_d = bus.branch_target & WORD_MASK;
    end else if (bus.jump) begin
      pc_d = bus.jump_target & WORD_MASK;
    end
  end

  // IF/ID next value: hold, insert a bubble, or capture the fetched word.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (bus.if_id_write) begin
      if (redirect) begin
        instr_d = 32'h0000_0000;
        pc4_d   = 32'h0000_0000;
        valid_d = 1'b0;
      end else begin
        instr_d = bus.imem_rdata;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  // Event counters stick at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!bus.pc_write && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (redirect && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State registers. Reset wins over stall, branch and jump in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC & WORD_MASK;
      instr_q     <= 32'h0000_0000;
      pc4_q       <= 32'h0000_0000;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc4   = pc4_q;
  assign bus.if_id_valid = valid_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand-written corner sequences
// (PC wrap, counter saturation) and randomized traffic against a reference model.
module tb_if_stage;

  localparam int CNT_W = 16;

  logic clk;
  logic rst_n;

  if_stage_if #(.CNT_W(CNT_W)) bus ();

  if_stage #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word at addr is 32'h1000 + addr.
  function automatic logic [31:0] imem(input logic [31:0] addr);
    return 32'h1000 + addr;
  endfunction

  always_comb bus.imem_rdata = imem(bus.imem_addr);

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_stall, m_flush;

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [31:0] old_pc;
    bit          flush;
    if (!rst_n) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_stall = 0; m_flush = 0;
    end else begin
      old_pc = m_pc;
      flush  = bus.if_id_write && (bus.branch_taken || bus.jump);
      if (bus.pc_write) begin
        if (bus.branch_taken)  m_pc = (bus.branch_target / 4) * 4;
        else if (bus.jump)     m_pc = (bus.jump_target / 4) * 4;
        else                   m_pc = 32'((64'(old_pc) + 4) % 64'h1_0000_0000);
      end
      if (bus.if_id_write) begin
        if (flush) begin
          m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else begin
          m_instr = imem(old_pc);
          m_pc4   = old_pc + 32'd4;
          m_valid = 1'b1;
        end
      end
      if (!bus.pc_write) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      if (flush)         m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},    bus.pc,          m_pc);
    chk({tag, ".addr"},  bus.imem_addr,   m_pc);
    chk({tag, ".instr"}, bus.if_id_instr, m_instr);
    chk({tag, ".pc4"},   bus.if_id_pc4,   m_pc4);
    chk({tag, ".valid"}, 32'(bus.if_id_valid), 32'(m_valid));
    chk({tag, ".stall"}, 32'(bus.stall_cnt),   32'(m_stall));
    chk({tag, ".flush"}, 32'(bus.flush_cnt),   32'(m_flush));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rn, input logic pw, input logic iw,
                       input logic bt, input logic [31:0] btgt,
                       input logic j,  input logic [31:0] jtgt);
    rst_n             = rn;
    bus.pc_write      = pw;
    bus.if_id_write   = iw;
    bus.branch_taken  = bt;
    bus.branch_target = btgt;
    bus.jump          = j;
    bus.jump_target   = jtgt;
  endtask

  // One clock: update model, take the edge, sample 1 time unit later.
  task automatic tick(input bit do_chk, input string tag);
    model_step();
    @(posedge clk);
    #1;
    if (do_chk) check_model(tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rn, pw, iw, bt, j;
    logic [31:0] btgt, jtgt;
    logic [31:0] e_pc, e_instr, e_pc4;
    logic        e_v;
    logic [15:0] e_s, e_f;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rn, input logic pw, input logic iw,
                     input logic bt, input logic [31:0] btgt,
                     input logic j, input logic [31:0] jtgt,
                     input logic [31:0] e_pc, input logic [31:0] e_instr,
                     input logic [31:0] e_pc4, input logic e_v,
                     input logic [15:0] e_s, input logic [15:0] e_f);
    vec_t v;
    v.rn = rn; v.pw = pw; v.iw = iw; v.bt = bt; v.btgt = btgt; v.j = j; v.jtgt = jtgt;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_v = e_v;
    v.e_s = e_s; v.e_f = e_f;
    tbl.push_back(v);
  endtask

  initial begin
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_stall = 0; m_flush = 0;

    //   rn pw iw bt btgt       j  jtgt       pc            instr         pc4           v  stall flush
    add(0, 0, 0, 0, 32'h0,     0, 32'h0,     32'h0,        32'h0,        32'h0,        0, 0, 0); // reset
    add(1, 1, 1, 0, 32'h0,     0, 32'h0,     32'h4,        32'h1000,     32'h4,        1, 0, 0);
    add(1, 1, 1, 0, 32'h0,     0, 32'h0,     32'h8,        32'h1004,     32'h8,        1, 0, 0);
    add(1, 1, 1, 0, 32'h0,     0, 32'h0,     32'hC,        32'h1008,     32'hC,        1, 0, 0);
    add(1, 1, 1, 0, 32'h0,     0, 32'h0,     32'h10,       32'h100C,     32'h10,       1, 0, 0);
    add(1, 0, 0, 0, 32'h0,     0, 32'h0,     32'h10,       32'h100C,     32'h10,       1, 1, 0); // stall 1
    add(1, 0, 0, 0, 32'h0,     0, 32'h0,     32'h10,       32'h100C,     32'h10,       1, 2, 0); // stall 2
    add(1, 1, 1, 0, 32'h0,     0, 32'h0,     32'h14,       32'h1010,     32'h14,       1, 2, 0);
    add(1, 1, 1, 0, 32'h0,     0, 32'h0,     32'h18,       32'h1014,     32'h18,       1, 2, 0);
    add(1, 1, 1, 0, 32'h0,     0, 32'h0,     32'h1C,       32'h1018,     32'h1C,       1, 2, 0);
    add(1, 1, 1, 0, 32'h0,     0, 32'h0,     32'h20,       32'h101C,     32'h20,       1, 2, 0);
    add(1, 1, 1, 1, 32'h103,   0, 32'h0,     32'h100,      32'h0,        32'h0,        0, 2, 1); // branch
    add(1, 1, 1, 0, 32'h0,     0, 32'h0,     32'h104,      32'h1100,     32'h104,      1, 2, 1);
    add(1, 1, 1, 1, 32'h200,   1, 32'h300,   32'h200,      32'h0,        32'h0,        0, 2, 2); // br beats jump
    add(1, 0, 0, 1, 32'h200,   1, 32'h300,   32'h200,      32'h0,        32'h0,        0, 3, 2); // stalled redirect
    add(1, 1, 1, 0, 32'h0,     1, 32'h307,   32'h304,      32'h0,        32'h0,        0, 3, 3); // jump
    add(1, 1, 1, 0, 32'h0,     0, 32'h0,     32'h308,      32'h1304,     32'h308,      1, 3, 3);
    add(1, 1, 0, 0, 32'h0,     0, 32'h0,     32'h30C,      32'h1304,     32'h308,      1, 3, 3); // IF/ID held only
    add(1, 0, 1, 0, 32'h0,     0, 32'h0,     32'h30C,      32'h130C,     32'h310,      1, 4, 3); // PC held only
    add(1, 0, 1, 1, 32'h500,   0, 32'h0,     32'h30C,      32'h0,        32'h0,        0, 5, 4); // flush while PC held
    add(0, 0, 1, 1, 32'h500,   1, 32'h600,   32'h0,        32'h0,        32'h0,        0, 0, 0); // reset wins

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rn, tbl[i].pw, tbl[i].iw, tbl[i].bt, tbl[i].btgt, tbl[i].j, tbl[i].jtgt);
      tick(1'b0, "tbl");
      chk($sformatf("tbl%0d.pc", i),    bus.pc,          tbl[i].e_pc);
      chk($sformatf("tbl%0d.instr", i), bus.if_id_instr, tbl[i].e_instr);
      chk($sformatf("tbl%0d.pc4", i),   bus.if_id_pc4,   tbl[i].e_pc4);
      chk($sformatf("tbl%0d.valid", i), 32'(bus.if_id_valid), 32'(tbl[i].e_v));
      chk($sformatf("tbl%0d.stall", i), 32'(bus.stall_cnt),   32'(tbl[i].e_s));
      chk($sformatf("tbl%0d.flush", i), 32'(bus.flush_cnt),   32'(tbl[i].e_f));
    end

    // ---- PC wrap: jump to the last word, then fall through to 0 ----
    drive(1, 1, 1, 0, 32'h0, 1, 32'hFFFF_FFFF);
    tick(1'b1, "wrap_jmp");
    chk("wrap_jmp.pc_const", bus.pc, 32'hFFFF_FFFC);
    drive(1, 1, 1, 0, 32'h0, 0, 32'h0);
    tick(1'b1, "wrap");
    chk("wrap.pc_const",    bus.pc,          32'h0000_0000);
    chk("wrap.pc4_const",   bus.if_id_pc4,   32'h0000_0000);
    chk("wrap.instr_const", bus.if_id_instr, 32'h0000_0FFC);

    // ---- stall counter saturation ----
    drive(0, 1, 1, 0, 32'h0, 0, 32'h0);
    tick(1'b1, "sat_rst");
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
    for (int k = 0; k < 65535; k++) tick(1'b0, "sat");
    chk("sat.stall_full", 32'(bus.stall_cnt), 32'h0000_FFFF);
    chk("sat.pc_held",    bus.pc,             32'h0);
    tick(1'b1, "sat_more");
    chk("sat.stall_stuck", 32'(bus.stall_cnt), 32'h0000_FFFF);

    // ---- randomized traffic against the model ----
    drive(0, 1, 1, 0, 32'h0, 0, 32'h0);
    tick(1'b1, "rnd_rst");
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 31) == 0) ? 1'b0 : 1'b1,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
            $urandom,
            ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
            $urandom);
      tick(1'b1, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
